// File: rtl/second_order_decim.sv
// Second-order CIC (sinc2) decimator recovering the fractional input word
// of a MASH 1-1 modulator from its 3-bit output code stream.
module second_order_decim #(
  parameter int BITS     = 8,
  parameter int DEC_LOG2 = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [2:0]      dn,
  output logic [BITS-1:0] f_est,
  output logic            out_valid,
  output logic            sat,
  output logic            err
);

  // Internal width holds the full sinc2 gain R^2 times the largest code plus sign.
  localparam int W     = 3 + 2 * DEC_LOG2;
  localparam int SHIFT = 2 * DEC_LOG2 - BITS;

  logic signed [W-1:0]  i1;
  logic signed [W-1:0]  i2;
  logic signed [W-1:0]  i2_d;
  logic signed [W-1:0]  c1_d;
  logic [DEC_LOG2-1:0]  cnt;
  logic                 settled;

  logic                 illegal;
  logic signed [2:0]    x3;
  logic signed [W-1:0]  x;
  logic signed [W-1:0]  i1_new;
  logic signed [W-1:0]  i2_new;
  logic signed [W-1:0]  c1;
  logic signed [W-1:0]  y;
  logic signed [W-1:0]  y_sh;
  logic [BITS-1:0]      f_next;
  logic                 sat_next;

  // Decode the code, run the integrators and combs one step ahead, and clip the scaled result.
  always_comb begin
    illegal  = (dn == 3'b011) || (dn[2] && (dn != 3'b111));
    x3       = illegal ? 3'sd0 : signed'(dn);
    x        = {{(W-3){x3[2]}}, x3};
    i1_new   = i1 + x;
    i2_new   = i2 + i1_new;
    c1       = i2_new - i2_d;
    y        = c1 - c1_d;
    y_sh     = y >>> SHIFT;
    f_next   = y_sh[BITS-1:0];
    sat_next = 1'b0;
    if (y_sh[W-1]) begin
      f_next   = '0;
      sat_next = 1'b1;
    end else if (|y_sh[W-2:BITS]) begin
      f_next   = '1;
      sat_next = 1'b1;
    end
  end

  // Advance state on accepted samples; the first decimation after reset only primes the combs.
  always_ff @(posedge clk) begin
    if (rst) begin
      i1        <= '0;
      i2        <= '0;
      i2_d      <= '0;
      c1_d      <= '0;
      cnt       <= '0;
      settled   <= 1'b0;
      f_est     <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (en) begin
        i1  <= i1_new;
        i2  <= i2_new;
        cnt <= cnt + 1'b1;
        if (illegal) begin
          err <= 1'b1;
        end
        if (cnt == '1) begin
          i2_d    <= i2_new;
          c1_d    <= c1;
          settled <= 1'b1;
          if (settled) begin
            f_est     <= f_next;
            sat       <= sat_next;
            out_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_second_order_decim.sv
// Self-checking bench for second_order_decim against a triangular-window sinc2 model.
module tb_second_order_decim;

  localparam int BITS     = 8;
  localparam int DEC_LOG2 = 5;
  localparam int R        = 32;
  localparam int SHIFT    = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en  = 1'b0;
  logic [2:0]      dn  = 3'b000;
  logic [BITS-1:0] f_est;
  logic            out_valid;
  logic            sat;
  logic            err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: accepted sample values since reset and expected outputs.
  int              hist[$];
  logic            exp_valid = 1'b0;
  logic [BITS-1:0] exp_f     = '0;
  logic            exp_sat   = 1'b0;
  logic            exp_err   = 1'b0;
  int              model_x;
  int              model_y;
  int              model_q;
  int              model_w;

  // MASH 1-1 modulator state for the closed-loop scenario.
  int mash_acc1;
  int mash_acc2;
  int mash_c2_prev;

  second_order_decim #(.BITS(BITS), .DEC_LOG2(DEC_LOG2)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .dn        (dn),
    .f_est     (f_est),
    .out_valid (out_valid),
    .sat       (sat),
    .err       (err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Behavioural model: every R-th accepted sample (once two windows exist) yields a triangular-weighted sum.
  always @(posedge clk) begin
    exp_valid = 1'b0;
    if (rst) begin
      hist.delete();
      exp_f   = '0;
      exp_sat = 1'b0;
      exp_err = 1'b0;
    end else if (en) begin
      case (dn)
        3'b000:  model_x = 0;
        3'b001:  model_x = 1;
        3'b010:  model_x = 2;
        3'b111:  model_x = -1;
        default: begin
          model_x = 0;
          exp_err = 1'b1;
        end
      endcase
      hist.push_back(model_x);
      if ((hist.size() % R == 0) && (hist.size() >= 2 * R)) begin
        model_y = 0;
        for (int j = 0; j < 2 * R - 1; j++) begin
          model_w = (j + 1 < 2 * R - 1 - j) ? j + 1 : 2 * R - 1 - j;
          model_y += model_w * hist[hist.size() - 1 - j];
        end
        model_q = model_y >>> SHIFT;
        if (model_q < 0) begin
          exp_f   = '0;
          exp_sat = 1'b1;
        end else if (model_q > (1 << BITS) - 1) begin
          exp_f   = '1;
          exp_sat = 1'b1;
        end else begin
          exp_f   = model_q[BITS-1:0];
          exp_sat = 1'b0;
        end
        exp_valid = 1'b1;
      end
    end
  end

  // Drive one cycle of inputs at the falling edge and return just after the rising edge.
  task automatic tick(input logic r, input logic e, input logic [2:0] d);
    @(negedge clk);
    rst = r;
    en  = e;
    dn  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic mash_reset();
    mash_acc1    = 0;
    mash_acc2    = 0;
    mash_c2_prev = 0;
  endtask

  task automatic mash_next(input int f, output logic [2:0] code);
    int s1, s2, c1, c2;
    s1 = mash_acc1 + f;
    c1 = s1 >> BITS;
    mash_acc1 = s1 & ((1 << BITS) - 1);
    s2 = mash_acc2 + mash_acc1;
    c2 = s2 >> BITS;
    mash_acc2 = s2 & ((1 << BITS) - 1);
    code = 3'(c1 + c2 - mash_c2_prev);
    mash_c2_prev = c2;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 3'b001);
    tick(1'b1, 1'b0, 3'b100);
    n_checks++;
    if ({out_valid, f_est, sat, err} !== {1'b0, 8'd0, 1'b0, 1'b0}) begin
      n_errors++;
      $display("[TB] FAIL reset_state got v=%b f=%0d s=%b e=%b expected all zero", out_valid, f_est, sat, err);
    end
  endtask

  task automatic test_zero();
    int first;
    int strobes;
    first   = -1;
    strobes = 0;
    tick(1'b1, 1'b0, 3'b000);
    for (int k = 1; k <= 128; k++) begin
      tick(1'b0, 1'b1, 3'b000);
      n_checks++;
      if ({out_valid, f_est, sat, err} !== {exp_valid, exp_f, exp_sat, exp_err}) begin
        n_errors++;
        $display("[TB] FAIL zero_cycle%0d got v=%b f=%0d s=%b e=%b expected v=%b f=%0d s=%b e=%b",
                 k, out_valid, f_est, sat, err, exp_valid, exp_f, exp_sat, exp_err);
      end
      if (out_valid) begin
        strobes++;
        if (first < 0) first = k;
      end
    end
    n_checks++;
    if (first !== 64) begin
      n_errors++;
      $display("[TB] FAIL zero_first_strobe got sample %0d expected 64", first);
    end
    n_checks++;
    if (strobes !== 3) begin
      n_errors++;
      $display("[TB] FAIL zero_strobe_count got %0d expected 3", strobes);
    end
  endtask

  task automatic test_alt();
    int strobes;
    strobes = 0;
    tick(1'b1, 1'b0, 3'b000);
    for (int k = 0; k < 160; k++) begin
      tick(1'b0, 1'b1, 3'(k & 1));
      n_checks++;
      if ({out_valid, f_est, sat, err} !== {exp_valid, exp_f, exp_sat, exp_err}) begin
        n_errors++;
        $display("[TB] FAIL alt_cycle%0d got v=%b f=%0d s=%b e=%b expected v=%b f=%0d s=%b e=%b",
                 k, out_valid, f_est, sat, err, exp_valid, exp_f, exp_sat, exp_err);
      end
      if (out_valid) begin
        strobes++;
        n_checks++;
        if ({f_est, sat} !== {8'd128, 1'b0}) begin
          n_errors++;
          $display("[TB] FAIL alt_value got f=%0d s=%b expected f=128 s=0", f_est, sat);
        end
      end
    end
    n_checks++;
    if (strobes !== 4) begin
      n_errors++;
      $display("[TB] FAIL alt_strobe_count got %0d expected 4", strobes);
    end
  endtask

  task automatic test_sat();
    logic [BITS-1:0] last_f;
    logic            last_sat;
    last_f   = 8'hAA;
    last_sat = 1'b0;
    tick(1'b1, 1'b0, 3'b000);
    for (int k = 0; k < 192; k++) begin
      tick(1'b0, 1'b1, (k < 96) ? 3'b001 : 3'b111);
      n_checks++;
      if ({out_valid, f_est, sat, err} !== {exp_valid, exp_f, exp_sat, exp_err}) begin
        n_errors++;
        $display("[TB] FAIL sat_cycle%0d got v=%b f=%0d s=%b e=%b expected v=%b f=%0d s=%b e=%b",
                 k, out_valid, f_est, sat, err, exp_valid, exp_f, exp_sat, exp_err);
      end
      if (out_valid && k < 96) begin
        n_checks++;
        if ({f_est, sat} !== {8'd255, 1'b1}) begin
          n_errors++;
          $display("[TB] FAIL sat_high got f=%0d s=%b expected f=255 s=1", f_est, sat);
        end
      end
      if (out_valid) begin
        last_f   = f_est;
        last_sat = sat;
      end
    end
    n_checks++;
    if ({last_f, last_sat} !== {8'd0, 1'b1}) begin
      n_errors++;
      $display("[TB] FAIL sat_low got f=%0d s=%b expected f=0 s=1", last_f, last_sat);
    end
  endtask

  task automatic test_en_toggle();
    int acc;
    int last_strobe;
    int strobes;
    acc         = 0;
    last_strobe = -1;
    strobes     = 0;
    tick(1'b1, 1'b0, 3'b000);
    for (int k = 0; k < 256; k++) begin
      if (k % 2 == 0) begin
        tick(1'b0, 1'b1, 3'(acc & 1));
        acc++;
      end else begin
        tick(1'b0, 1'b0, 3'($urandom_range(0, 7)));
      end
      n_checks++;
      if ({out_valid, f_est, sat, err} !== {exp_valid, exp_f, exp_sat, exp_err}) begin
        n_errors++;
        $display("[TB] FAIL entog_cycle%0d got v=%b f=%0d s=%b e=%b expected v=%b f=%0d s=%b e=%b",
                 k, out_valid, f_est, sat, err, exp_valid, exp_f, exp_sat, exp_err);
      end
      if (out_valid) begin
        strobes++;
        n_checks++;
        if ({f_est, sat} !== {8'd128, 1'b0}) begin
          n_errors++;
          $display("[TB] FAIL entog_value got f=%0d s=%b expected f=128 s=0", f_est, sat);
        end
        if (last_strobe >= 0) begin
          n_checks++;
          if (k - last_strobe !== 64) begin
            n_errors++;
            $display("[TB] FAIL entog_interval got %0d expected 64", k - last_strobe);
          end
        end
        last_strobe = k;
      end
    end
    n_checks++;
    if (strobes !== 3) begin
      n_errors++;
      $display("[TB] FAIL entog_strobe_count got %0d expected 3", strobes);
    end
  endtask

  task automatic test_err();
    tick(1'b1, 1'b0, 3'b000);
    for (int k = 0; k < 100; k++) begin
      tick(1'b0, 1'b1, (k == 10) ? 3'b100 : 3'b000);
      n_checks++;
      if ({out_valid, f_est, sat, err} !== {exp_valid, exp_f, exp_sat, exp_err}) begin
        n_errors++;
        $display("[TB] FAIL err_cycle%0d got v=%b f=%0d s=%b e=%b expected v=%b f=%0d s=%b e=%b",
                 k, out_valid, f_est, sat, err, exp_valid, exp_f, exp_sat, exp_err);
      end
      if (k >= 10) begin
        n_checks++;
        if (err !== 1'b1) begin
          n_errors++;
          $display("[TB] FAIL err_sticky cycle %0d got %b expected 1", k, err);
        end
      end
    end
    for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, 3'b000);
    n_checks++;
    if (err !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL err_idle got %b expected 1", err);
    end
    tick(1'b1, 1'b1, 3'b101);
    n_checks++;
    if (err !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL err_clear got %b expected 0", err);
    end
  endtask

  task automatic test_mash();
    logic [2:0] code;
    int         after_rst;
    int         first;
    first     = -1;
    after_rst = -1;
    mash_reset();
    tick(1'b1, 1'b0, 3'b000);
    for (int k = 0; k < 300; k++) begin
      if (k == 40) begin
        tick(1'b1, 1'b1, 3'b000);
        after_rst = 0;
      end else begin
        mash_next(8'h40, code);
        tick(1'b0, 1'b1, code);
        if (after_rst >= 0) after_rst++;
      end
      n_checks++;
      if ({out_valid, f_est, sat, err} !== {exp_valid, exp_f, exp_sat, exp_err}) begin
        n_errors++;
        $display("[TB] FAIL mash_cycle%0d got v=%b f=%0d s=%b e=%b expected v=%b f=%0d s=%b e=%b",
                 k, out_valid, f_est, sat, err, exp_valid, exp_f, exp_sat, exp_err);
      end
      if (out_valid) begin
        if (first < 0 && after_rst >= 0) first = after_rst;
        n_checks++;
        if (f_est < 8'd60 || f_est > 8'd68) begin
          n_errors++;
          $display("[TB] FAIL mash_range got f=%0d expected 60..68", f_est);
        end
      end
    end
    n_checks++;
    if (first !== 64) begin
      n_errors++;
      $display("[TB] FAIL mash_first_strobe got sample %0d expected 64", first);
    end
  endtask

  task automatic test_random();
    logic [2:0] code;
    logic       r;
    logic       e;
    tick(1'b1, 1'b0, 3'b000);
    for (int k = 0; k < 800; k++) begin
      case ($urandom_range(0, 3))
        0:       code = 3'b111;
        1:       code = 3'b000;
        2:       code = 3'b001;
        default: code = 3'b010;
      endcase
      if ($urandom_range(0, 199) == 0) code = 3'b011;
      r = ($urandom_range(0, 299) == 0);
      e = ($urandom_range(0, 3) != 0);
      tick(r, e, code);
      n_checks++;
      if ({out_valid, f_est, sat, err} !== {exp_valid, exp_f, exp_sat, exp_err}) begin
        n_errors++;
        $display("[TB] FAIL rand_cycle%0d got v=%b f=%0d s=%b e=%b expected v=%b f=%0d s=%b e=%b",
                 k, out_valid, f_est, sat, err, exp_valid, exp_f, exp_sat, exp_err);
      end
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_zero();
    test_alt();
    test_sat();
    test_en_toggle();
    test_err();
    test_mash();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/second_order_decim.md
SECOND_ORDER_DECIM -- requirements
Module: second_order_decim

Interface
REQ-001 SHALL have parameter BITS, default 8, meaning width of the recovered fractional word f_est (equal to the modulator's f width).
REQ-002 SHALL have parameter DEC_LOG2, default 5, meaning log2 of decimation ratio R = 2^DEC_LOG2; 2*DEC_LOG2 >= BITS is required.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  sample qualifier; dn is accepted only on cycles with en=1.
REQ-006 SHALL have port dn  input  3  MASH 1-1 output code, 3-bit two's complement, legal values -1, 0, 1, 2.
REQ-007 SHALL have port f_est  output  BITS  recovered estimate of the modulator input word.
REQ-008 SHALL have port out_valid  output  1  single-cycle strobe, f_est updated this cycle.
REQ-009 SHALL have port sat  output  1  asserted with out_valid when f_est was clipped.
REQ-010 SHALL have port err  output  1  sticky flag, an illegal dn code (3'b011, 3'b100, 3'b101, 3'b110) was accepted.

Function
REQ-011 SHALL implement a second-order CIC (sinc2) decimator, with integrators at input rate and combs at rate 1/R.
REQ-012 SHALL decode an accepted dn as signed x; an illegal code SHALL be treated as x=0 and SHALL set err.
REQ-013 SHALL use internal signed width W = 3 + 2*DEC_LOG2 for integrators and combs, with modulo-2^W wrap-around (no saturation internally).
REQ-014 SHALL, on each accepted sample, update i1 <= i1 + x and i2 <= i2 + i1 + x (i2 uses the updated i1 value).
REQ-015 SHALL keep a sample counter 0..R-1 that advances only on accepted samples and wraps R-1 -> 0.
REQ-016 SHALL raise a decimation event when a sample is accepted with counter = R-1.
REQ-017 SHALL, at each decimation event, compute c1 = i2_new - i2_d and y = c1 - c1_d, then store i2_d <= i2_new and c1_d <= c1.
REQ-018 SHALL derive f_est = y >>> (2*DEC_LOG2 - BITS) (arithmetic), clipped to [0, 2^BITS - 1]; sat=1 when clipping occurred, else 0.
REQ-019 SHALL register f_est, sat and out_valid so they update exactly 1 clk after the cycle in which the decimation event sample was accepted.
REQ-020 SHALL hold f_est and sat stable between strobes; out_valid SHALL be high for exactly one cycle per reported event.
REQ-021 SHALL suppress out_valid for the first decimation event after reset (comb not settled); f_est and sat SHALL NOT change on it.
REQ-022 SHALL, with en=0, freeze integrators, counter and combs; a pending output strobe SHALL still occur on its scheduled cycle.
REQ-023 SHALL keep err set until reset, regardless of en or later legal codes.

Reset
REQ-024 SHALL, on rst=1 at posedge, clear i1, i2, i2_d, c1_d, the counter and the settle flag to 0, and drive f_est=0, out_valid=0, sat=0, err=0.
REQ-025 SHALL give rst priority over en and over any same-cycle decimation event; a reset mid-window SHALL discard the partial window, and the next event SHALL again be suppressed.

Verification (BITS=8, DEC_LOG2=5: R=32, shift 2)
REQ-026 SHALL cover: rst then dn=0 constant, en=1 -> first out_valid 1 clk after the 64th accepted sample, f_est=0, sat=0, and a strobe every 32 samples thereafter.
REQ-027 SHALL cover: dn alternating 0,1 -> f_est=128, sat=0 on every reported strobe.
REQ-028 SHALL cover: dn=1 constant -> y=1024, f_est=255, sat=1; then dn=-1 (3'b111) constant -> f_est=0, sat=1 once the comb has settled.
REQ-029 SHALL cover: en toggled 1,0,1,0 with dn alternating 0,1 on accepted samples -> results identical to REQ-027, with strobes every 64 clk.
REQ-030 SHALL cover: a single dn=3'b100 injected -> err=1 and stays 1; that sample counts as 0, and err clears only on rst.
REQ-031 SHALL cover: the MASH modulator (f=0x40) driving dn, plus rst asserted for 1 cycle at sample 40 -> no strobe until 64 samples after reset release, then f_est within 64+/-4.
